// File: rtl/z_writeback_stage_pkg.sv
// z_writeback_stage_pkg: shared encodings and width defaults for the write-back stage
package z_writeback_stage_pkg;
  localparam int DEF_DATA_W = 32;
  localparam int DEF_REG_ADDR_W = 4;
  localparam logic [1:0] WB_SEL_GPR = 2'b00;
  localparam logic [1:0] WB_SEL_LO = 2'b01;
  localparam logic [1:0] WB_SEL_HI = 2'b10;
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BEAT_LO = 2'd1,
    BEAT_HI = 2'd2,
    BEAT_GPR = 2'd3
  } wb_state_t;
endpackage

// File: rtl/z_writeback_stage_result_queue.sv
// z_writeback_stage_result_queue: DEPTH-entry FIFO exposing the head and the entry behind it
module z_writeback_stage_result_queue #(
  parameter int W = 8,
  parameter int DEPTH = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic         full,
  output logic         empty,
  output logic         multi,
  output logic [W-1:0] head,
  output logic [W-1:0] next_head
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);
  localparam logic [AW:0] ONE = (AW+1)'(1);
  logic [AW:0] wr_ptr, rd_ptr, rd_nxt, count;
  logic [W-1:0] mem [DEPTH];
  assign count = wr_ptr - rd_ptr;
  assign rd_nxt = rd_ptr + ONE;
  assign full = count == FULL_CNT;
  assign empty = count == '0;
  assign multi = count > ONE;
  assign head = mem[rd_ptr[AW-1:0]];
  assign next_head = mem[rd_nxt[AW-1:0]];
  always_ff @(posedge clk)
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + ONE;
      if (pop) rd_ptr <= rd_nxt;
    end
  always_ff @(posedge clk)
    if (push) mem[wr_ptr[AW-1:0]] <= din;
endmodule

// File: rtl/z_writeback_stage.sv
// z_writeback_stage: captures ALU results into the Z pair and retires them to GPR or LO/HI
module z_writeback_stage
  import z_writeback_stage_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int DEPTH = 2,
  parameter int REG_ADDR_W = DEF_REG_ADDR_W
) (
  input  logic                  clock,
  input  logic                  clear,
  input  logic [2*DATA_W-1:0]   C,
  input  logic                  Zin,
  input  logic                  wide,
  input  logic [REG_ADDR_W-1:0] dest_addr,
  output logic                  z_ready,
  output logic [DATA_W-1:0]     ZLow_out,
  output logic [DATA_W-1:0]     ZHigh_out,
  output logic                  wb_valid,
  input  logic                  wb_ready,
  output logic [1:0]            wb_sel,
  output logic [REG_ADDR_W-1:0] wb_addr,
  output logic [DATA_W-1:0]     wb_data
);
  localparam int EW = 2*DATA_W + 1 + REG_ADDR_W;
  wb_state_t state;
  logic full, empty, multi, push, pop, more, go_load, go_idle, src_wide;
  logic [EW-1:0] din, head, next_head, src;
  logic [DATA_W-1:0] hi_q;
  assign din = {C, wide, dest_addr};
  assign push = Zin && !full;
  assign pop = wb_valid && wb_ready && (state == BEAT_GPR || state == BEAT_HI);
  assign more = multi || push;
  assign go_load = state == IDLE ? !empty : pop && more;
  assign go_idle = pop && !more;
  assign z_ready = !full;
  // after a pop the next beat comes from the entry behind the head, or straight from C when that entry is being pushed now
  assign src = state == IDLE ? head : multi ? next_head : din;
  assign src_wide = src[REG_ADDR_W];
  z_writeback_stage_result_queue #(.W(EW), .DEPTH(DEPTH)) u_result_queue (
    .clk(clock),
    .rst(clear),
    .push(push),
    .pop(pop),
    .din(din),
    .full(full),
    .empty(empty),
    .multi(multi),
    .head(head),
    .next_head(next_head)
  );
  always_ff @(posedge clock)
    if (clear) begin
      state <= IDLE;
      wb_valid <= 1'b0;
      wb_sel <= WB_SEL_GPR;
      wb_addr <= '0;
      wb_data <= '0;
      hi_q <= '0;
      ZLow_out <= '0;
      ZHigh_out <= '0;
    end else begin
      if (push) begin
        ZHigh_out <= C[2*DATA_W-1:DATA_W];
        ZLow_out <= C[DATA_W-1:0];
      end
      if (go_load) begin
        state <= src_wide ? BEAT_LO : BEAT_GPR;
        wb_valid <= 1'b1;
        wb_sel <= src_wide ? WB_SEL_LO : WB_SEL_GPR;
        wb_addr <= src_wide ? '0 : src[REG_ADDR_W-1:0];
        wb_data <= src[REG_ADDR_W+1 +: DATA_W];
        hi_q <= src[EW-1 -: DATA_W];
      end else if (state == BEAT_LO && wb_ready) begin
        state <= BEAT_HI;
        wb_sel <= WB_SEL_HI;
        wb_data <= hi_q;
      end else if (go_idle) begin
        state <= IDLE;
        wb_valid <= 1'b0;
        wb_sel <= WB_SEL_GPR;
        wb_addr <= '0;
        wb_data <= '0;
      end
    end
endmodule

// File: tb/tb_z_writeback_stage.sv
// tb_z_writeback_stage: directed and random stimulus against a queue-of-beats scoreboard
module tb_z_writeback_stage;
  localparam int DEPTH = 2;
  typedef struct {
    logic [1:0]  sel;
    logic [3:0]  addr;
    logic [31:0] data;
    bit          last;
  } beat_t;
  logic clock = 1'b0, clear = 1'b1, Zin = 1'b0, wide = 1'b0, wb_ready = 1'b0;
  logic [63:0] C = '0;
  logic [3:0] dest_addr = '0;
  logic z_ready, wb_valid;
  logic [31:0] ZLow_out, ZHigh_out, wb_data;
  logic [1:0] wb_sel;
  logic [3:0] wb_addr;
  beat_t exp_q[$];
  int n_chk = 0, n_fail = 0, model_cnt = 0, stall = 0;
  logic [31:0] m_lo = '0, m_hi = '0;

  always #5 clock = ~clock;

  z_writeback_stage #(.DATA_W(32), .DEPTH(DEPTH), .REG_ADDR_W(4)) dut (
    .clock(clock),
    .clear(clear),
    .C(C),
    .Zin(Zin),
    .wide(wide),
    .dest_addr(dest_addr),
    .z_ready(z_ready),
    .ZLow_out(ZLow_out),
    .ZHigh_out(ZHigh_out),
    .wb_valid(wb_valid),
    .wb_ready(wb_ready),
    .wb_sel(wb_sel),
    .wb_addr(wb_addr),
    .wb_data(wb_data)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, req, $time);
    end
  endtask

  task automatic cyc();
    @(posedge clock);
    #2;
  endtask

  task automatic cap(input logic [63:0] c, input logic w, input logic [3:0] d);
    Zin = 1'b1;
    C = c;
    wide = w;
    dest_addr = d;
  endtask

  // Reference model: every accepted result becomes one (narrow) or two (LO then HI) expected beats.
  always @(negedge clock) begin
    int pre;
    pre = model_cnt;
    if (clear) begin
      exp_q.delete();
      model_cnt = 0;
      m_lo = '0;
      m_hi = '0;
      stall = 0;
    end else begin
      chk("z_ready", {63'd0, z_ready}, {63'd0, pre < DEPTH});
      chk("ZLow_out", {32'd0, ZLow_out}, {32'd0, m_lo});
      chk("ZHigh_out", {32'd0, ZHigh_out}, {32'd0, m_hi});
      if (wb_valid) begin
        stall = 0;
        if (exp_q.size() == 0) chk("spurious wb_valid", {63'd0, wb_valid}, 64'd0);
        else begin
          chk("beat sel/addr/data", {26'd0, wb_sel, wb_addr, wb_data},
              {26'd0, exp_q[0].sel, exp_q[0].addr, exp_q[0].data});
          if (wb_ready) begin
            if (exp_q[0].last) model_cnt--;
            void'(exp_q.pop_front());
          end
        end
      end else if (exp_q.size() != 0) begin
        stall++;
        if (stall > 3) begin
          chk("beat timeout wb_valid", {63'd0, wb_valid}, 64'd1);
          stall = 0;
        end
      end
      if (Zin && pre < DEPTH) begin
        m_lo = C[31:0];
        m_hi = C[63:32];
        model_cnt++;
        if (wide) begin
          exp_q.push_back('{sel: 2'b01, addr: 4'd0, data: C[31:0], last: 1'b0});
          exp_q.push_back('{sel: 2'b10, addr: 4'd0, data: C[63:32], last: 1'b1});
        end else exp_q.push_back('{sel: 2'b00, addr: dest_addr, data: C[31:0], last: 1'b1});
      end
    end
  end

  initial begin
    cyc();
    cyc();
    clear = 1'b0;
    chk("reset wb_valid", {63'd0, wb_valid}, 64'd0);
    chk("reset wb_sel", {62'd0, wb_sel}, 64'd0);
    chk("reset wb_addr", {60'd0, wb_addr}, 64'd0);
    chk("reset wb_data", {32'd0, wb_data}, 64'd0);
    chk("reset z_ready", {63'd0, z_ready}, 64'd1);
    chk("reset Z", {ZHigh_out, ZLow_out}, 64'd0);
    // narrow ADD
    wb_ready = 1'b1;
    cap(64'h7, 1'b0, 4'd5);
    cyc();
    Zin = 1'b0;
    chk("t1 ZLow", {32'd0, ZLow_out}, 64'd7);
    chk("t1 no early valid", {63'd0, wb_valid}, 64'd0);
    cyc();
    chk("t1 beat", {25'd0, wb_valid, wb_sel, wb_addr, wb_data}, {25'd0, 1'b1, 2'b00, 4'd5, 32'd7});
    cyc();
    chk("t1 idle", {63'd0, wb_valid}, 64'd0);
    // wide MUL
    cap(64'hFFFF_FFFE_0000_0002, 1'b1, 4'd0);
    cyc();
    Zin = 1'b0;
    chk("t2 ZHigh", {32'd0, ZHigh_out}, 64'hFFFF_FFFE);
    cyc();
    chk("t2 LO beat", {25'd0, wb_valid, wb_sel, wb_addr, wb_data}, {25'd0, 1'b1, 2'b01, 4'd0, 32'h2});
    cyc();
    chk("t2 HI beat", {25'd0, wb_valid, wb_sel, wb_addr, wb_data}, {25'd0, 1'b1, 2'b10, 4'd0, 32'hFFFF_FFFE});
    cyc();
    chk("t2 idle", {63'd0, wb_valid}, 64'd0);
    // backpressure
    wb_ready = 1'b0;
    cap(64'h7, 1'b0, 4'd5);
    cyc();
    Zin = 1'b0;
    for (int i = 0; i < 4; i++) begin
      cyc();
      chk("t3 held beat", {25'd0, wb_valid, wb_sel, wb_addr, wb_data}, {25'd0, 1'b1, 2'b00, 4'd5, 32'd7});
    end
    wb_ready = 1'b1;
    cyc();
    chk("t3 retired", {63'd0, wb_valid}, 64'd0);
    // full queue
    wb_ready = 1'b0;
    cap(64'd1, 1'b0, 4'd3);
    cyc();
    cap(64'd2, 1'b0, 4'd3);
    chk("t4 ready after 1", {63'd0, z_ready}, 64'd1);
    cyc();
    cap(64'd3, 1'b0, 4'd3);
    chk("t4 full after 2", {63'd0, z_ready}, 64'd0);
    cyc();
    Zin = 1'b0;
    chk("t4 drop keeps ZLow", {32'd0, ZLow_out}, 64'd2);
    chk("t4 still full", {63'd0, z_ready}, 64'd0);
    chk("t4 first beat", {32'd0, wb_data}, 64'd1);
    wb_ready = 1'b1;
    cyc();
    chk("t4 second beat", {31'd0, wb_valid, wb_data}, {31'd0, 1'b1, 32'd2});
    cyc();
    chk("t4 idle", {63'd0, wb_valid}, 64'd0);
    // push and pop together
    cap(64'd8, 1'b0, 4'd2);
    cyc();
    Zin = 1'b0;
    cyc();
    chk("t5 beat 8", {32'd0, wb_data}, 64'd8);
    cap(64'd9, 1'b0, 4'd6);
    cyc();
    Zin = 1'b0;
    chk("t5 bypass beat 9", {26'd0, wb_valid, z_ready, wb_addr, wb_data}, {26'd0, 1'b1, 1'b1, 4'd6, 32'd9});
    cyc();
    chk("t5 idle", {63'd0, wb_valid}, 64'd0);
    // clear during BEAT_LO
    wb_ready = 1'b0;
    cap(64'hAAAA_BBBB_CCCC_DDDD, 1'b1, 4'd0);
    cyc();
    cap(64'h1234, 1'b0, 4'd7);
    cyc();
    Zin = 1'b0;
    chk("t6 in BEAT_LO", {61'd0, wb_valid, wb_sel}, {61'd0, 1'b1, 2'b01});
    clear = 1'b1;
    cyc();
    clear = 1'b0;
    chk("t6 cleared", {26'd0, wb_valid, z_ready, wb_addr, wb_data}, {26'd0, 1'b0, 1'b1, 4'd0, 32'd0});
    chk("t6 Z cleared", {ZHigh_out, ZLow_out}, 64'd0);
    wb_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      cyc();
      chk("t6 no beats", {63'd0, wb_valid}, 64'd0);
    end
    // random traffic
    for (int i = 0; i < 1500; i++) begin
      clear = $urandom_range(0, 199) == 0;
      Zin = $urandom_range(0, 2) != 0;
      C = {$urandom, $urandom};
      wide = 1'($urandom_range(0, 1));
      dest_addr = 4'($urandom_range(0, 15));
      wb_ready = $urandom_range(0, 3) != 0;
      cyc();
    end
    clear = 1'b0;
    Zin = 1'b0;
    wb_ready = 1'b1;
    for (int i = 0; i < 20 && exp_q.size() != 0; i++) cyc();
    chk("drain", 64'(exp_q.size()), 64'd0);
    cyc();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
